// File: rtl/spi_transaction_arbiter_pkg.sv
// Shared types and sizing helpers for the SPI transaction arbiter.
// Purely declarative: no latency, no flow control.
package spi_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RSP,
    DELIVER
  } spi_arbiter_state_t;

  localparam int   DEFAULT_TIMEOUT_CYCLES = 4096;
  localparam int   TIMEOUT_WIDTH          = $clog2(DEFAULT_TIMEOUT_CYCLES) + 1;
  localparam logic ERR_FILL_BIT           = 1'b1;

  function automatic int timeout_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/spi_transaction_arbiter_if.sv
// Client request/response streams plus the spi_master mosi/miso streams.
// master = arbiter side, slave = clients and spi_master side.
interface spi_transaction_arbiter_if
  import spi_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int TRANSFER_WIDTH = 8
);

  logic [NUM_REQUESTERS*TRANSFER_WIDTH-1:0] req_tdata;
  logic [NUM_REQUESTERS-1:0]                req_tvalid;
  logic [NUM_REQUESTERS-1:0]                req_tlast;
  logic [NUM_REQUESTERS-1:0]                req_tready;
  logic [TRANSFER_WIDTH-1:0]                rsp_tdata;
  logic [NUM_REQUESTERS-1:0]                rsp_tvalid;
  logic                                     rsp_tlast;
  logic                                     rsp_tuser;
  logic [NUM_REQUESTERS-1:0]                rsp_tready;
  logic [TRANSFER_WIDTH-1:0]                m_mosi_tdata;
  logic                                     m_mosi_tvalid;
  logic                                     m_mosi_tready;
  logic [TRANSFER_WIDTH-1:0]                m_miso_tdata;
  logic                                     m_miso_tvalid;
  logic                                     m_miso_tready;

  modport master (
    input  req_tdata, req_tvalid, req_tlast, rsp_tready,
    input  m_mosi_tready, m_miso_tdata, m_miso_tvalid,
    output req_tready, rsp_tdata, rsp_tvalid, rsp_tlast, rsp_tuser,
    output m_mosi_tdata, m_mosi_tvalid, m_miso_tready
  );

  modport slave (
    output req_tdata, req_tvalid, req_tlast, rsp_tready,
    output m_mosi_tready, m_miso_tdata, m_miso_tvalid,
    input  req_tready, rsp_tdata, rsp_tvalid, rsp_tlast, rsp_tuser,
    input  m_mosi_tdata, m_mosi_tvalid, m_miso_tready
  );

endinterface

// File: rtl/spi_transaction_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
// Zero latency; no flow control (pointer register lives in the parent).
module rr_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic [NUM_REQUESTERS-1:0]         req_i,
  input  logic [$clog2(NUM_REQUESTERS)-1:0] ptr_i,
  output logic [NUM_REQUESTERS-1:0]         grant_o
);

  localparam int PW  = $clog2(NUM_REQUESTERS);
  localparam int PW1 = PW + 1;

  logic [PW:0] pos;
  logic        found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      pos = {1'b0, ptr_i} + PW1'(k);
      if (pos >= PW1'(NUM_REQUESTERS)) pos = pos - PW1'(NUM_REQUESTERS);
      if (!found && req_i[pos[PW-1:0]]) begin
        grant_o[pos[PW-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_transaction_arbiter.sv
// Shares one spi_master word datapath between clients, one whole transaction at a time.
// One word in flight: send MOSI, await MISO (or timeout), hold response until the owner accepts.
module spi_transaction_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int TRANSFER_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset_n,
  spi_transaction_arbiter_if.master bus,
  output logic [NUM_REQUESTERS-1:0] grant,
  output logic                      busy
);

  localparam int N  = NUM_REQUESTERS;
  localparam int W  = TRANSFER_WIDTH;
  localparam int PW = $clog2(NUM_REQUESTERS);
  localparam int TW = timeout_width(TIMEOUT_CYCLES);

  spi_arbiter_state_t state_q, state_d;
  logic [N-1:0]  grant_q, grant_d, win;
  logic [PW-1:0] idx_q, idx_d, ptr_q, ptr_d, win_idx;
  logic          last_q, last_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rsp_data_q, rsp_data_d;
  logic          rsp_user_q, rsp_user_d;

  logic [W-1:0]  req_word [N];
  logic [N-1:0]  req_tready_c, rsp_tvalid_c;
  logic [W-1:0]  mosi_dat_c;
  logic          mosi_vld_c, miso_rdy_c;

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign req_word[gi] = bus.req_tdata[gi*W +: W];
  end

  rr_arbiter #(.NUM_REQUESTERS(N)) u_rr (
    .req_i   (bus.req_tvalid),
    .ptr_i   (ptr_q),
    .grant_o (win)
  );

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (win[k]) win_idx = PW'(k);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_user_d   = rsp_user_q;
    req_tready_c = '0;
    rsp_tvalid_c = '0;
    mosi_dat_c   = '0;
    mosi_vld_c   = 1'b0;
    miso_rdy_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_tvalid) begin
          grant_d = win;
          idx_d   = win_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        mosi_vld_c          = bus.req_tvalid[idx_q];
        mosi_dat_c          = req_word[idx_q];
        req_tready_c[idx_q] = bus.m_mosi_tready;
        if (bus.req_tvalid[idx_q] && bus.m_mosi_tready) begin
          last_d  = bus.req_tlast[idx_q];
          cnt_d   = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        miso_rdy_c = 1'b1;
        // A word landing on the timeout cycle is real data, so it is checked first.
        if (bus.m_miso_tvalid) begin
          rsp_data_d = bus.m_miso_tdata;
          rsp_user_d = 1'b0;
          state_d    = DELIVER;
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d = {W{ERR_FILL_BIT}};
          rsp_user_d = 1'b1;
          state_d    = DELIVER;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      DELIVER: begin
        rsp_tvalid_c[idx_q] = 1'b1;
        if (bus.rsp_tready[idx_q]) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = (idx_q == PW'(N - 1)) ? '0 : idx_q + PW'(1);
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_user_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_user_q <= rsp_user_d;
    end
  end

  assign bus.req_tready    = req_tready_c;
  assign bus.rsp_tvalid    = rsp_tvalid_c;
  assign bus.rsp_tdata     = rsp_data_q;
  assign bus.rsp_tlast     = (state_q == DELIVER) && last_q;
  assign bus.rsp_tuser     = rsp_user_q;
  assign bus.m_mosi_tdata  = mosi_dat_c;
  assign bus.m_mosi_tvalid = mosi_vld_c;
  assign bus.m_miso_tready = miso_rdy_c;
  assign grant             = grant_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_spi_transaction_arbiter.sv
// Directed bench: bench plays the clients and the spi_master; expected values are hand-computed.
module tb_spi_transaction_arbiter;
  import spi_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] grant;
  logic         busy;
  int           checks = 0;
  int           errors = 0;

  spi_transaction_arbiter_if #(.NUM_REQUESTERS(N), .TRANSFER_WIDTH(W)) bus ();

  spi_transaction_arbiter #(
    .NUM_REQUESTERS (N),
    .TRANSFER_WIDTH (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    bus.req_tdata     = '0;
    bus.req_tvalid    = '0;
    bus.req_tlast     = '0;
    bus.rsp_tready    = '0;
    bus.m_mosi_tready = 1'b0;
    bus.m_miso_tdata  = '0;
    bus.m_miso_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Client c offers one word; returns the MOSI word seen and the cycles until it was taken.
  task automatic mosi_phase(input int c, input logic [7:0] d, input logic last,
                            output logic [7:0] seen, output int lat);
    bus.req_tdata[c*W +: W] = d;
    bus.req_tlast[c]        = last;
    bus.req_tvalid[c]       = 1'b1;
    bus.m_mosi_tready       = 1'b1;
    seen = 'x;
    lat  = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.m_mosi_tvalid && bus.req_tready[c]) begin
        seen = bus.m_mosi_tdata;
        lat  = i;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req_tvalid[c] = 1'b0;
    bus.req_tlast[c]  = 1'b0;
    bus.m_mosi_tready = 1'b0;
  endtask

  task automatic miso_phase(input logic [7:0] d, input int delay, output int ok);
    repeat (delay) @(negedge clk);
    bus.m_miso_tdata  = d;
    bus.m_miso_tvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.m_miso_tready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.m_miso_tvalid = 1'b0;
    bus.m_miso_tdata  = '0;
  endtask

  task automatic rsp_phase(input int c, output logic [7:0] d, output logic l,
                           output logic u, output int lat);
    d   = 'x;
    l   = 1'bx;
    u   = 1'bx;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.rsp_tvalid[c]) begin
        d   = bus.rsp_tdata;
        l   = bus.rsp_tlast;
        u   = bus.rsp_tuser;
        lat = i;
        break;
      end
      @(negedge clk);
    end
    bus.rsp_tready[c] = 1'b1;
    @(negedge clk);
    bus.rsp_tready[c] = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus.req_tready !== 4'b0000) begin errors++; $display("FAIL reset_req_tready: got %b expected 0000", bus.req_tready); end
    checks++; if (bus.rsp_tvalid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_tvalid: got %b expected 0000", bus.rsp_tvalid); end
    checks++; if (bus.rsp_tdata !== 8'h00) begin errors++; $display("FAIL reset_rsp_tdata: got %h expected 00", bus.rsp_tdata); end
    checks++; if ({bus.rsp_tlast, bus.rsp_tuser} !== 2'b00) begin errors++; $display("FAIL reset_rsp_flags: got %b expected 00", {bus.rsp_tlast, bus.rsp_tuser}); end
    checks++; if ({bus.m_mosi_tvalid, bus.m_miso_tready} !== 2'b00) begin errors++; $display("FAIL reset_master_hs: got %b expected 00", {bus.m_mosi_tvalid, bus.m_miso_tready}); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if ({busy, grant} !== 5'b0) begin errors++; $display("FAIL idle_after_reset: got %b expected 00000", {busy, grant}); end
    @(negedge clk);
  endtask

  task automatic test_single_client();
    logic [7:0] w   [3] = '{8'hA1, 8'hA2, 8'hA3};
    logic [7:0] exp [3] = '{8'h5E, 8'h5D, 8'h5C};
    logic [7:0] seen, rd;
    logic rl, ru;
    int lat, ok;
    for (int i = 0; i < 3; i++) begin
      mosi_phase(1, w[i], (i == 2), seen, lat);
      checks++; if (seen !== w[i]) begin errors++; $display("FAIL single_mosi[%0d]: got %h expected %h", i, seen, w[i]); end
      checks++; if (lat !== ((i == 0) ? 1 : 0)) begin errors++; $display("FAIL single_send_latency[%0d]: got %0d expected %0d", i, lat, (i == 0) ? 1 : 0); end
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL single_grant[%0d]: got %b expected 0010", i, grant); end
      miso_phase(~w[i], 2, ok);
      checks++; if (ok !== 1) begin errors++; $display("FAIL single_miso_accept[%0d]: got %0d expected 1", i, ok); end
      rsp_phase(1, rd, rl, ru, lat);
      checks++; if (rd !== exp[i]) begin errors++; $display("FAIL single_rsp_data[%0d]: got %h expected %h", i, rd, exp[i]); end
      checks++; if ({rl, ru} !== {(i == 2), 1'b0}) begin errors++; $display("FAIL single_rsp_last_user[%0d]: got %b expected %b", i, {rl, ru}, {(i == 2), 1'b0}); end
    end
    #1;
    checks++; if ({busy, grant} !== 5'b0) begin errors++; $display("FAIL single_release: got %b expected 00000", {busy, grant}); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [7:0] seen, rd;
    logic rl, ru;
    int lat, ok;
    do_reset();
    bus.req_tdata[0*W +: W] = 8'h10;
    bus.req_tdata[2*W +: W] = 8'h20;
    bus.req_tlast  = 4'b0101;
    bus.req_tvalid = 4'b0101;
    @(negedge clk);
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rr_first_grant: got %b expected 0001", grant); end
    mosi_phase(0, 8'h10, 1'b1, seen, lat);
    checks++; if (seen !== 8'h10) begin errors++; $display("FAIL rr_mosi0: got %h expected 10", seen); end
    miso_phase(8'h90, 1, ok);
    bus.req_tdata[0*W +: W] = 8'h30;
    bus.req_tlast[0]  = 1'b1;
    bus.req_tvalid[0] = 1'b1;
    rsp_phase(0, rd, rl, ru, lat);
    checks++; if (rd !== 8'h90) begin errors++; $display("FAIL rr_rsp0: got %h expected 90", rd); end
    @(negedge clk);
    #1;
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL rr_second_grant: got %b expected 0100", grant); end
    mosi_phase(2, 8'h20, 1'b1, seen, lat);
    checks++; if (seen !== 8'h20) begin errors++; $display("FAIL rr_mosi2: got %h expected 20", seen); end
    miso_phase(8'hA0, 1, ok);
    rsp_phase(2, rd, rl, ru, lat);
    checks++; if (rd !== 8'hA0) begin errors++; $display("FAIL rr_rsp2: got %h expected a0", rd); end
    mosi_phase(0, 8'h30, 1'b1, seen, lat);
    checks++; if ({seen, grant} !== {8'h30, 4'b0001}) begin errors++; $display("FAIL rr_third: got %h/%b expected 30/0001", seen, grant); end
    miso_phase(8'hB0, 1, ok);
    rsp_phase(0, rd, rl, ru, lat);
    checks++; if (rd !== 8'hB0) begin errors++; $display("FAIL rr_rsp0b: got %h expected b0", rd); end
  endtask

  task automatic test_no_preempt();
    logic [7:0] seen, rd;
    logic rl, ru;
    int lat, ok;
    mosi_phase(3, 8'hB1, 1'b0, seen, lat);
    checks++; if ({seen, grant} !== {8'hB1, 4'b1000}) begin errors++; $display("FAIL np_first: got %h/%b expected b1/1000", seen, grant); end
    bus.req_tdata[0*W +: W] = 8'hC0;
    bus.req_tlast[0]  = 1'b1;
    bus.req_tvalid[0] = 1'b1;
    bus.m_mosi_tready = 1'b1;
    #1;
    checks++; if ({bus.req_tready, bus.m_mosi_tvalid} !== 5'b0) begin errors++; $display("FAIL np_wait_quiet: got %b expected 00000", {bus.req_tready, bus.m_mosi_tvalid}); end
    bus.m_mosi_tready = 1'b0;
    miso_phase(8'h4E, 1, ok);
    rsp_phase(3, rd, rl, ru, lat);
    checks++; if ({rd, rl} !== {8'h4E, 1'b0}) begin errors++; $display("FAIL np_rsp1: got %h/%b expected 4e/0", rd, rl); end
    bus.m_mosi_tready = 1'b1;
    #1;
    checks++; if ({bus.req_tready, bus.m_mosi_tvalid} !== 5'b10000) begin errors++; $display("FAIL np_send_gap: got %b expected 10000", {bus.req_tready, bus.m_mosi_tvalid}); end
    mosi_phase(3, 8'hB2, 1'b1, seen, lat);
    checks++; if (seen !== 8'hB2) begin errors++; $display("FAIL np_mosi2: got %h expected b2", seen); end
    miso_phase(8'h4D, 2, ok);
    bus.m_mosi_tready = 1'b1;
    #1;
    checks++; if (bus.req_tready !== 4'b0000) begin errors++; $display("FAIL np_deliver_ready: got %b expected 0000", bus.req_tready); end
    bus.m_mosi_tready = 1'b0;
    rsp_phase(3, rd, rl, ru, lat);
    checks++; if ({rd, rl} !== {8'h4D, 1'b1}) begin errors++; $display("FAIL np_rsp2: got %h/%b expected 4d/1", rd, rl); end
    mosi_phase(0, 8'hC0, 1'b1, seen, lat);
    checks++; if ({seen, grant, lat} !== {8'hC0, 4'b0001, 32'd1}) begin errors++; $display("FAIL np_waiter: got %h/%b/%0d expected c0/0001/1", seen, grant, lat); end
    miso_phase(8'h3F, 1, ok);
    rsp_phase(0, rd, rl, ru, lat);
    checks++; if (rd !== 8'h3F) begin errors++; $display("FAIL np_waiter_rsp: got %h expected 3f", rd); end
  endtask

  task automatic test_timeout();
    logic [7:0] seen, rd;
    logic rl, ru;
    int lat, ok;
    mosi_phase(1, 8'hD1, 1'b0, seen, lat);
    rsp_phase(1, rd, rl, ru, lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL to_latency: got %0d expected 16", lat); end
    checks++; if ({rd, ru, rl} !== {8'hFF, 1'b1, 1'b0}) begin errors++; $display("FAIL to_error_rsp: got %h/%b/%b expected ff/1/0", rd, ru, rl); end
    mosi_phase(1, 8'hD2, 1'b1, seen, lat);
    checks++; if ({seen, lat} !== {8'hD2, 32'd0}) begin errors++; $display("FAIL to_continue_mosi: got %h/%0d expected d2/0", seen, lat); end
    miso_phase(8'h42, 3, ok);
    rsp_phase(1, rd, rl, ru, lat);
    checks++; if ({rd, ru, rl} !== {8'h42, 1'b0, 1'b1}) begin errors++; $display("FAIL to_recover_rsp: got %h/%b/%b expected 42/0/1", rd, ru, rl); end
    mosi_phase(2, 8'hE1, 1'b1, seen, lat);
    miso_phase(8'h77, 15, ok);
    checks++; if (ok !== 1) begin errors++; $display("FAIL to_tie_accept: got %0d expected 1", ok); end
    rsp_phase(2, rd, rl, ru, lat);
    checks++; if ({rd, ru} !== {8'h77, 1'b0}) begin errors++; $display("FAIL to_tie_rsp: got %h/%b expected 77/0", rd, ru); end
  endtask

  task automatic test_backpressure();
    logic [7:0] seen, rd;
    logic rl, ru;
    int lat, ok;
    mosi_phase(0, 8'hF0, 1'b1, seen, lat);
    miso_phase(8'h5A, 1, ok);
    bus.req_tdata[0*W +: W] = 8'hF1;
    bus.req_tlast[0]  = 1'b1;
    bus.req_tvalid[0] = 1'b1;
    bus.m_mosi_tready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++; if ({bus.rsp_tvalid, bus.rsp_tdata, bus.m_mosi_tvalid} !== {4'b0001, 8'h5A, 1'b0}) begin
        errors++; $display("FAIL bp_hold[%0d]: got %b/%h/%b expected 0001/5a/0", k, bus.rsp_tvalid, bus.rsp_tdata, bus.m_mosi_tvalid);
      end
      @(negedge clk);
    end
    bus.m_mosi_tready = 1'b0;
    rsp_phase(0, rd, rl, ru, lat);
    checks++; if ({rd, rl, lat} !== {8'h5A, 1'b1, 32'd0}) begin errors++; $display("FAIL bp_rsp: got %h/%b/%0d expected 5a/1/0", rd, rl, lat); end
    mosi_phase(0, 8'hF1, 1'b1, seen, lat);
    checks++; if (seen !== 8'hF1) begin errors++; $display("FAIL bp_next_mosi: got %h expected f1", seen); end
    miso_phase(8'h0E, 1, ok);
    rsp_phase(0, rd, rl, ru, lat);
  endtask

  task automatic test_reset_mid();
    logic [7:0] seen, rd;
    logic rl, ru;
    int lat, ok;
    mosi_phase(2, 8'h66, 1'b1, seen, lat);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({busy, grant, bus.m_miso_tready, bus.m_mosi_tvalid} !== 7'b0) begin errors++; $display("FAIL rm_async_ctrl: got %b expected 0000000", {busy, grant, bus.m_miso_tready, bus.m_mosi_tvalid}); end
    checks++; if ({bus.rsp_tvalid, bus.rsp_tdata} !== 12'h000) begin errors++; $display("FAIL rm_async_rsp: got %h expected 000", {bus.rsp_tvalid, bus.rsp_tdata}); end
    clear_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus.req_tdata[3*W +: W] = 8'h03;
    bus.req_tlast[3]  = 1'b1;
    bus.req_tvalid[3] = 1'b1;
    mosi_phase(0, 8'h01, 1'b1, seen, lat);
    checks++; if ({seen, grant} !== {8'h01, 4'b0001}) begin errors++; $display("FAIL rm_priority: got %h/%b expected 01/0001", seen, grant); end
    miso_phase(8'h11, 1, ok);
    rsp_phase(0, rd, rl, ru, lat);
    checks++; if (rd !== 8'h11) begin errors++; $display("FAIL rm_rsp0: got %h expected 11", rd); end
    mosi_phase(3, 8'h03, 1'b1, seen, lat);
    checks++; if (seen !== 8'h03) begin errors++; $display("FAIL rm_mosi3: got %h expected 03", seen); end
    miso_phase(8'h33, 1, ok);
    rsp_phase(3, rd, rl, ru, lat);
    #1;
    checks++; if ({rd, busy} !== {8'h33, 1'b0}) begin errors++; $display("FAIL rm_final: got %h/%b expected 33/0", rd, busy); end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_client();
    test_round_robin();
    test_no_preempt();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_transaction_arbiter.md
Name: spi_transaction_arbiter

Overview:
- Shares one spi_master byte datapath between NUM_REQUESTERS clients.
- A transaction is a multi-byte request stream terminated by tlast. It is granted whole, round-robin, and never interleaved with another client.
- Exactly one byte is in flight at a time: send MOSI byte, wait for the matching MISO byte, return it to the owner.
- Sits between client AXI-stream ports and the spi_master mosi_stream / miso_stream.

Parameters:
- NUM_REQUESTERS, 4, number of client ports (2..16).
- TRANSFER_WIDTH, 8, bits per SPI word; matches spi_master.
- TIMEOUT_CYCLES, 4096, max clk cycles waited for a MISO word before an error response.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_tdata  in  NUM_REQUESTERS*TRANSFER_WIDTH  client MOSI words; slice i is client i.
- req_tvalid  in  NUM_REQUESTERS  client word valid.
- req_tlast  in  NUM_REQUESTERS  last word of client transaction.
- req_tready  out  NUM_REQUESTERS  word accepted.
- rsp_tdata  out  TRANSFER_WIDTH  MISO word returned; shared by all clients.
- rsp_tvalid  out  NUM_REQUESTERS  response valid; one-hot to the owner.
- rsp_tlast  out  1  response is for the transaction's last word.
- rsp_tuser  out  1  1 = timeout error; tdata is then all ones.
- rsp_tready  in  NUM_REQUESTERS  client accepts response.
- m_mosi_tdata  out  TRANSFER_WIDTH  to spi_master mosi_stream.
- m_mosi_tvalid  out  1  to spi_master mosi_stream.
- m_mosi_tready  in  1  from spi_master mosi_stream.
- m_miso_tdata  in  TRANSFER_WIDTH  from spi_master miso_stream.
- m_miso_tvalid  in  1  from spi_master miso_stream.
- m_miso_tready  out  1  to spi_master miso_stream.
- grant  out  NUM_REQUESTERS  one-hot current owner; 0 when idle.
- busy  out  1  transaction in progress.

Behaviour:
- Reset (async assert, sync release) forces:
  - state IDLE, grant 0, busy 0, rr pointer 0.
  - all tvalid/tready outputs 0, rsp_tdata 0, rsp_tlast 0, rsp_tuser 0, timeout counter 0.
- IDLE:
  - If any req_tvalid is set, pick the first requester at or after the rr pointer (wrapping).
  - Register grant, set busy, go SEND. Grant is visible one cycle after req_tvalid is first seen.
- SEND:
  - m_mosi_tvalid = req_tvalid[g]; m_mosi_tdata = slice g.
  - req_tready[g] = m_mosi_tready; all other req_tready stay 0.
  - On handshake: latch req_tlast[g], clear the timeout counter, go WAIT_RSP.
- WAIT_RSP:
  - m_miso_tready = 1.
  - On m_miso_tvalid: register the data into rsp_tdata, rsp_tuser = 0, go DELIVER.
  - Otherwise increment the counter. At TIMEOUT_CYCLES-1: rsp_tdata = all ones, rsp_tuser = 1, go DELIVER.
  - A MISO word arriving in the same cycle as the timeout wins; no error is flagged.
- DELIVER:
  - rsp_tvalid[g] = 1; rsp_tlast = latched last.
  - Hold until rsp_tready[g] is seen.
  - If last: go IDLE, clear grant and busy, set rr pointer = (g+1) mod NUM_REQUESTERS.
  - Else: go SEND.
- A timeout does not abort the transaction; the owner still sends its remaining words.
- m_miso_tready is 0 outside WAIT_RSP. Stray MISO words are left unaccepted.
- Non-owner tvalid is ignored until its turn. Arbitration happens only in IDLE.
- Requests arriving mid-transaction wait; no preemption.
- One word pair per transaction is the minimum (tlast on first word).
- Throughput: at most one word per (SPI word time + 3 clk).
- Reset mid-transaction: immediate abandon; no response is delivered.

Decomposition:
- Package spi_arbiter_pkg:
  - state enum spi_arbiter_state_t {IDLE, SEND, WAIT_RSP, DELIVER}.
  - TIMEOUT_WIDTH = $clog2(TIMEOUT_CYCLES)+1.
  - Error fill constant.
- Sub-module rr_arbiter:
  - Parameters: NUM_REQUESTERS.
  - Inputs: request vector, pointer. Output: one-hot winner.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
1. Client 1 sends 3 words 0xA1,0xA2,0xA3 (tlast on 0xA3); master echoes inverted → client 1 gets 0x5E,0x5D,0x5C, rsp_tlast on third only, grant=0b0010 throughout, busy drops after last rsp_tready.
2. Clients 0 and 2 both valid in IDLE after reset → client 0 served first, then client 2. Next, 0 and 2 again → 2 first (pointer=1).
3. Client 3 mid-transaction while client 0 raises tvalid → req_tready[0] stays 0 until client 3's tlast response is accepted; no interleaved m_mosi words.
4. Slave never returns MISO (TIMEOUT_CYCLES=16) → after 16 cycles in WAIT_RSP, rsp_tdata=0xFF with rsp_tuser=1; next word proceeds normally.
5. Hold rsp_tready low 10 cycles → rsp_tvalid and rsp_tdata stable; m_mosi_tvalid stays 0 meanwhile.
6. Assert reset_n low during WAIT_RSP → all outputs 0 asynchronously; after release, a new request is granted from client 0 priority.
